// File: rtl/sb_cfg_pkg.sv
// Shared types and constants for the switch-box configuration loader.
// Pure declarations: no logic, no latency, no flow control.
package sb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [7:0] END_ADDR       = 8'hFF;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         CFG_W          = 32;

endpackage

// File: rtl/cfg_byte_assembler.sv
// Little-endian 8-to-32 lane register; word_next is the word including the byte being shifted now.
// Zero latency on word_next/last_byte; no backpressure of its own, the owner gates shift.
module cfg_byte_assembler
    import sb_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic [7:0]       data_byte,
    output logic [CFG_W-1:0] word_next,
    output logic             last_byte
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt;
    logic [CFG_W-1:0] word_q;

    // The incoming byte is merged combinationally so the owner can commit on the 4th byte's edge.
    always_comb begin
        word_next = word_q;
        word_next[{cnt, 3'b000} +: 8] = data_byte;
    end

    assign last_byte = (cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            word_q <= '0;
        end else if (clear) begin
            cnt    <= '0;
            word_q <= '0;
        end else if (shift) begin
            word_q <= word_next;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sb_config_loader.sv
// Byte-serial bitstream loader: address byte + 4 LE data bytes -> one-hot config_en pulse with config_data.
// config_en fires the cycle after the 4th data byte; in_ready drops for the commit cycle and forever after done.
module sb_config_loader
    import sb_cfg_pkg::*;
#(
    parameter int NUM_TILES = 16,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    config_data,
    output logic [NUM_TILES-1:0] config_en,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          words_loaded
);

    localparam logic [7:0] NT = 8'(NUM_TILES);

    state_t           state;
    logic [7:0]       addr_q;
    logic             drop_q;
    logic             xfer;
    logic [CFG_W-1:0] word_next;
    logic             last_byte;

    assign xfer = in_valid && in_ready;

    cfg_byte_assembler u_asm (
        .clk       (clk),
        .rst_n     (reset),
        .clear     ((state == IDLE) && xfer),
        .shift     ((state == DATA) && xfer),
        .data_byte (in_byte),
        .word_next (word_next),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            config_data  <= '0;
            config_en    <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            addr_q       <= '0;
            drop_q       <= 1'b0;
        end else begin
            config_en <= '0;
            case (state)
                IDLE: begin
                    in_ready <= !done;
                    if (xfer) begin
                        if (in_byte == END_ADDR) begin
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            // Out-of-range frames are still consumed so the stream stays aligned.
                            addr_q <= in_byte;
                            drop_q <= !(in_byte < NT);
                            if (!(in_byte < NT)) begin
                                err <= 1'b1;
                            end
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer && last_byte) begin
                        if (drop_q) begin
                            state <= IDLE;
                        end else begin
                            state       <= COMMIT;
                            in_ready    <= 1'b0;
                            config_data <= DATA_W'(word_next);
                            for (int i = 0; i < NUM_TILES; i++) begin
                                config_en[i] <= (addr_q == 8'(i));
                            end
                            if (words_loaded != 16'hFFFF) begin
                                words_loaded <= words_loaded + 16'd1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed bench for sb_config_loader: stimulus pushes expected commits, a negedge monitor pops and compares.
module tb_sb_config_loader;

    typedef struct packed {
        logic [15:0] en;
        logic [31:0] data;
        logic [15:0] wl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] config_data;
    logic [15:0] config_en;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    exp_t exp_q[$];
    logic [15:0] prev_en = '0;

    always #5 clk = ~clk;

    sb_config_loader #(.NUM_TILES(16), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .config_data  (config_data),
        .config_en    (config_en),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every nonzero config_en must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (config_en != '0) begin
            pulses++;
            check("en_single_cycle", {31'd0, prev_en != '0}, 32'd0);
            check("ready_low_in_commit", {31'd0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_commit: got en=%h data=%h expected no commit", config_en, config_data);
            end else begin
                e = exp_q.pop_front();
                check("commit_en", {16'd0, config_en}, {16'd0, e.en});
                check("commit_data", config_data, e.data);
                check("commit_words", {16'd0, words_loaded}, {16'd0, e.wl});
            end
        end
        prev_en = config_en;
    end

    // Called at a negedge; returns at the negedge after the byte transfers.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d,
                              input bit commit, input logic [15:0] wl);
        exp_t e;
        if (commit) begin
            e.en   = 16'(1) << a;
            e.data = d;
            e.wl   = wl;
            exp_q.push_back(e);
        end
        send_byte(a);
        for (int i = 0; i < 4; i++) send_byte(d[i*8 +: 8]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_en", {16'd0, config_en}, 32'd0);
        check("rst_data", config_data, 32'd0);
        check("rst_flags", {30'd0, done, err}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, in_valid held high
        send_frame(8'h03, 32'hDEADBEEF, 1'b1, 16'd1);
        check("lat_en", {16'd0, config_en}, 32'h0008);
        @(negedge clk);
        check("en_cleared", {16'd0, config_en}, 32'd0);
        check("data_held", config_data, 32'hDEADBEEF);
        check("ready_after_commit", {31'd0, in_ready}, 32'd1);

        // Same frame with a 3-cycle valid gap
        e.en = 16'h0008; e.data = 32'hDEADBEEF; e.wl = 16'd2;
        exp_q.push_back(e);
        send_byte(8'h03); send_byte(8'hEF); send_byte(8'hBE);
        for (int i = 0; i < 3; i++) begin
            check("ready_during_gap", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        send_byte(8'hAD); send_byte(8'hDE);
        check("gap_lat_en", {16'd0, config_en}, 32'h0008);
        @(negedge clk);

        // Out-of-range address is consumed and dropped
        send_frame(8'h20, 32'h44332211, 1'b0, 16'd0);
        repeat (2) @(negedge clk);
        check("bad_addr_err", {31'd0, err}, 32'd1);
        check("bad_addr_words", {16'd0, words_loaded}, 32'd2);
        send_frame(8'h00, 32'h00000001, 1'b1, 16'd3);
        @(negedge clk);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Async reset after the 2nd data byte
        send_byte(8'h07); send_byte(8'h11); send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, in_ready}, 32'd0);
        check("arst_data", config_data, 32'd0);
        check("arst_flags", {30'd0, done, err}, 32'd0);
        check("arst_words", {16'd0, words_loaded}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h05, 32'hDDCCBBAA, 1'b1, 16'd1);
        check("post_arst_en", {16'd0, config_en}, 32'h0020);
        @(negedge clk);

        // Back-to-back sweep of all tiles
        do_reset();
        pulses = 0;
        for (int t = 0; t < 16; t++) begin
            send_frame(8'(t), 32'hA5000000 | 32'(t * 32'h00010101), 1'b1, 16'(t + 1));
        end
        repeat (3) @(negedge clk);
        check("sweep_pulses", 32'(pulses), 32'd16);
        check("sweep_words", {16'd0, words_loaded}, 32'd16);

        // End marker: loader stops accepting
        send_byte(8'hFF);
        check("done_set", {31'd0, done}, 32'd1);
        check("ready_after_done", {31'd0, in_ready}, 32'd0);
        in_byte  = 8'h03;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("ready_stays_low", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("done_sticky", {31'd0, done}, 32'd1);
        check("done_words", {16'd0, words_loaded}, 32'd16);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
